data_memory_lsu: RTL and testbench
==================================

DATA_MEMORY_LSU -- requirements
Module: data_memory_lsu

Interface
REQ-001 Parameter WORDS, default 256: number of 32-bit words; power of two, minimum 4.
REQ-002 Parameter WAIT_CYCLES, default 0: extra access cycles, range 0..7.
REQ-003 Localparam ADDR_W = $clog2(WORDS)+2: byte-address width.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 req_unsigned  in  1  load zero-extends when 1 and sign-extends when 0.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  32  store data, right-aligned.
REQ-013 rsp_valid  out  1  single-cycle response pulse.
REQ-014 rsp_rdata  out  32  load result, extended; 0 for stores and errors.
REQ-015 rsp_err  out  1  request rejected; valid only with rsp_valid.

Function
REQ-016 FSM states:
- IDLE: req_ready=1.
- WAIT: req_ready=0; present only when WAIT_CYCLES>0.
- RESP: req_ready=0, rsp_valid=1.
REQ-017 Accept on req_valid&&req_ready; capture we/size/unsigned/addr/wdata into registers.
REQ-018 Transitions:
- IDLE->WAIT on accept when WAIT_CYCLES>0, loading counter with WAIT_CYCLES-1.
- IDLE->RESP on accept when WAIT_CYCLES==0.
- WAIT->RESP when counter==0; otherwise decrement.
- RESP->IDLE unconditionally.
REQ-019 Latency: request accepted at edge N gives rsp_valid high in the cycle after edge N+1+WAIT_CYCLES; one outstanding request; no response backpressure.
REQ-020 Store commit: memory updated on the clock edge entering RESP; only enabled byte lanes change.
REQ-021 Write lanes by size and addr[1:0] (little-endian):
- byte: lane addr[1:0], data wdata[7:0].
- half: lanes {addr[1],0} and {addr[1],1}, data wdata[15:0].
- word: all four lanes.
REQ-022 Load data is sampled from memory on the edge entering RESP, selecting the lane(s) per REQ-021, then extended to 32 bits per req_unsigned.
REQ-023 Word index = addr[ADDR_W-1:2]; no address wrap or out-of-range case exists.
REQ-024 req_size==11: rsp_err=1, no memory change, rsp_rdata=0.
REQ-025 req_valid while req_ready=0 is ignored, not queued.

Reset
REQ-026 Asynchronous reset value: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0, capture registers=0.
REQ-027 Memory array is not reset.
REQ-028 Reset asserted in WAIT aborts the access; the pending store never commits.
REQ-029 Reset asserted in RESP deasserts rsp_valid immediately.

Configuration
REQ-030 Macro DMEM_MISALIGN_TRAP_EN defined: a halfword with addr[0]=1 or a word with addr[1:0]!=00 gives rsp_err=1, no write, rsp_rdata=0.
REQ-031 Macro undefined: misaligned addresses are force-aligned (halfword clears bit 0, word clears bits 1:0); rsp_err is set only per REQ-024.

Structure
REQ-032 Package dmem_pkg holds the size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL), the FSM state enum and the WAIT_CYCLES maximum constant.
REQ-033 Sub-module dmem_lane_align (combinational) produces the 4-bit write mask, the lane-shifted write data and the extended load result.

Verification
REQ-034 Verification scenarios:
- Store word 0xDEADBEEF @0x10, then load word @0x10: rsp_rdata=0xDEADBEEF, rsp_err=0.
- Store byte 0x80 @0x13, then load signed byte @0x13: 0xFFFFFF80; load unsigned: 0x00000080; load word @0x10: 0x80ADBEEF.
- WAIT_CYCLES=3, request accepted at edge N: rsp_valid high exactly in the cycle after edge N+4; req_ready=0 from edge N+1 until rsp_valid drops.
- Store halfword @0x21 with the macro defined: rsp_err=1 and memory unchanged. With the macro undefined: lanes 0-1 of word 8 are written.
- req_size=11: rsp_err=1 and no write occurs.
- WAIT_CYCLES=2, store 0x12345678 @0x40, rst_n low during WAIT: the following load @0x40 returns the prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory load/store unit: access size, FSM state
// and the upper bound on configurable wait cycles.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   localparam int WAIT_CYCLES_MAX = 7;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte mask and replicated write data,
// plus lane extraction and sign/zero extension of load data.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  offset_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wmask_o,
   output logic [31:0] wdata_o,
   output logic [31:0] load_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Halfword and word offsets ignore their low bits, which force-aligns them.
   always_comb begin
      wmask_o = 4'b0000;
      wdata_o = 32'h0;
      load_o  = 32'h0;
      byte_v  = rdata_i[{offset_i, 3'b000} +: 8];
      half_v  = rdata_i[{offset_i[1], 4'b0000} +: 16];
      case (size_i)
         SZ_BYTE: begin
            wmask_o = 4'b0001 << offset_i;
            wdata_o = {4{wdata_i[7:0]}};
            load_o  = {{24{~unsigned_i & byte_v[7]}}, byte_v};
         end
         SZ_HALF: begin
            wmask_o = offset_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
            load_o  = {{16{~unsigned_i & half_v[15]}}, half_v};
         end
         SZ_WORD: begin
            wmask_o = 4'b1111;
            wdata_o = wdata_i;
            load_o  = rdata_i;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/data_memory_lsu.sv
// Single-outstanding load/store unit over a byte-lane data memory.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module data_memory_lsu
   import dmem_pkg::*;
#(
   parameter int WORDS       = 256,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [1:0]               req_size,
   input  logic                     req_unsigned,
   input  logic [$clog2(WORDS)+1:0] req_addr,
   input  logic [31:0]              req_wdata,
   output logic                     rsp_valid,
   output logic [31:0]              rsp_rdata,
   output logic                     rsp_err
);

   localparam int ADDR_W   = $clog2(WORDS) + 2;
   localparam int WAIT_EFF = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
   localparam logic [2:0] CNT_INIT = 3'((WAIT_EFF > 0) ? WAIT_EFF - 1 : 0);

   state_e            state_q;
   logic [2:0]        cnt_q;
   logic              we_q, uns_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              req_ready_q, rsp_valid_q, rsp_err_q;
   logic [31:0]       rsp_rdata_q;

   logic              accept, in_idle, enter_resp, mem_we;
   logic              f_we, f_uns, f_misalign, f_err;
   logic [1:0]        f_size;
   logic [ADDR_W-1:0] f_addr;
   logic [31:0]       f_wdata, wdata_lane, load_ext, rd_word;
   logic [3:0]        wmask;

   assign accept     = req_valid && req_ready_q;
   assign in_idle    = (state_q == ST_IDLE);
   assign enter_resp = (in_idle && accept && (WAIT_EFF == 0)) ||
                       ((state_q == ST_WAIT) && (cnt_q == 3'd0));

   // With no wait states the access happens on the accept edge, so the live
   // request is used while idle and the captured copy afterwards.
   assign f_we    = in_idle ? req_we       : we_q;
   assign f_size  = in_idle ? req_size     : size_q;
   assign f_uns   = in_idle ? req_unsigned : uns_q;
   assign f_addr  = in_idle ? req_addr     : addr_q;
   assign f_wdata = in_idle ? req_wdata    : wdata_q;

`ifdef DMEM_MISALIGN_TRAP_EN
   assign f_misalign = ((f_size == SZ_HALF) && f_addr[0]) ||
                       ((f_size == SZ_WORD) && (f_addr[1:0] != 2'b00));
`else
   assign f_misalign = 1'b0;
`endif

   assign f_err  = (f_size == SZ_ILL) || f_misalign;
   assign mem_we = rst_n && enter_resp && f_we && !f_err;

   dmem_lane_align u_align (
      .size_i     (f_size),
      .offset_i   (f_addr[1:0]),
      .unsigned_i (f_uns),
      .wdata_i    (f_wdata),
      .rdata_i    (rd_word),
      .wmask_o    (wmask),
      .wdata_o    (wdata_lane),
      .load_o     (load_ext)
   );

   // One byte-wide RAM per lane with a registered read port; no reset.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [WORDS];
      logic [7:0] rd_lane_q;

      always_ff @(posedge clk) begin
         rd_lane_q <= lane_mem[f_addr[ADDR_W-1:2]];
         if (mem_we && wmask[gi]) begin
            lane_mem[f_addr[ADDR_W-1:2]] <= wdata_lane[gi*8 +: 8];
         end
      end

      assign rd_word[gi*8 +: 8] = rd_lane_q;
   end

   // Outputs are registered from the current state, so the response pulse
   // trails the RESP state by one cycle and ready stays low through it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
      end else begin
         req_ready_q <= in_idle && !accept;
         rsp_valid_q <= (state_q == ST_RESP);
         rsp_err_q   <= (state_q == ST_RESP) && f_err;
         rsp_rdata_q <= ((state_q == ST_RESP) && !f_we && !f_err) ? load_ext : 32'h0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  we_q    <= req_we;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (WAIT_EFF > 0) begin
                     state_q <= ST_WAIT;
                     cnt_q   <= CNT_INIT;
                  end else begin
                     state_q <= ST_RESP;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == 3'd0) state_q <= ST_RESP;
               else               cnt_q   <= cnt_q - 3'd1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Self-checking bench for data_memory_lsu: three instances (0, 3 and 2 wait
// cycles), a directed table, reset corner sequences and random traffic.
module tb_data_memory_lsu;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic [2:0]  rst_n_v = 3'b000;
   logic [2:0]  req_valid_v = 3'b000;
   logic [2:0]  req_ready_v, rsp_valid_v, rsp_err_v;
   logic [31:0] rsp_rdata_v [3];
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [9:0]  req_addr = 10'h0;
   logic [31:0] req_wdata = 32'h0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  mm [3][128];
   vec_t        tbl [$];

   always #5 clk = ~clk;

   function automatic int wc_of(input int d);
      return (d == 1) ? 3 : (d == 2) ? 2 : 0;
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      data_memory_lsu #(.WORDS(256), .WAIT_CYCLES(wc_of(gi))) dut (
         .clk          (clk),
         .rst_n        (rst_n_v[gi]),
         .req_valid    (req_valid_v[gi]),
         .req_ready    (req_ready_v[gi]),
         .req_we       (req_we),
         .req_size     (req_size),
         .req_unsigned (req_unsigned),
         .req_addr     (req_addr),
         .req_wdata    (req_wdata),
         .rsp_valid    (rsp_valid_v[gi]),
         .rsp_rdata    (rsp_rdata_v[gi]),
         .rsp_err      (rsp_err_v[gi])
      );
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   // Byte-array reference: size gives a byte count, misaligned accesses are
   // rounded down (or rejected when trapping), loads assemble little-endian.
   task automatic model_op(input int d, input logic we, input logic [1:0] size, input logic uns,
                           input int addr, input logic [31:0] wdata,
                           output logic err, output logic [31:0] rdata);
      int n, ea;
      logic [31:0] v;
      err = 1'b0;
      rdata = 32'h0;
      if (size == 2'b11) begin
         err = 1'b1;
         return;
      end
      n = 1 << size;
      if (TRAP && (addr % n) != 0) begin
         err = 1'b1;
         return;
      end
      ea = addr - (addr % n);
      if (we) begin
         for (int i = 0; i < n; i++) mm[d][ea + i] = wdata[8*i +: 8];
      end else begin
         v = 32'h0;
         for (int i = 0; i < n; i++) v = v | (32'(mm[d][ea + i]) << (8 * i));
         if (!uns && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
         rdata = v;
      end
   endtask

   task automatic xact(input int d, input logic we, input logic [1:0] size, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wdata,
                       output logic err, output logic [31:0] rdata);
      int k;
      bit seen, busy_ok;
      @(negedge clk);
      check("ready_before_req", 32'(req_ready_v[d]), 32'd1);
      req_we = we;
      req_size = size;
      req_unsigned = uns;
      req_addr = addr;
      req_wdata = wdata;
      req_valid_v[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_v[d] = 1'b0;
      k = 0;
      seen = 1'b0;
      busy_ok = 1'b1;
      err = 1'b0;
      rdata = 32'h0;
      while (!seen && k <= 12) begin
         if (k >= 1 && req_ready_v[d]) busy_ok = 1'b0;
         if (rsp_valid_v[d]) begin
            seen = 1'b1;
            err = rsp_err_v[d];
            rdata = rsp_rdata_v[d];
         end else begin
            k++;
            @(negedge clk);
         end
      end
      check("rsp_latency", 32'(k), 32'(1 + wc_of(d)));
      check("ready_low_while_busy", 32'(busy_ok), 32'd1);
      @(negedge clk);
      check("rsp_valid_single_pulse", 32'(rsp_valid_v[d]), 32'd0);
      check("ready_after_rsp", 32'(req_ready_v[d]), 32'd1);
      $display("xact dut%0d we=%0b size=%0d uns=%0b addr=0x%03h wdata=0x%08h -> err=%0b rdata=0x%08h lat=%0d",
               d, we, size, uns, addr, wdata, err, rdata, k);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "bench timed out");
   end

   logic        got_err, exp_err;
   logic [31:0] got_rdata, exp_rdata, prior;

   initial begin
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("reset_ready", 32'(req_ready_v[d]), 32'd1);
         check("reset_rsp_valid", 32'(rsp_valid_v[d]), 32'd0);
         check("reset_rsp_rdata", rsp_rdata_v[d], 32'h0);
         check("reset_rsp_err", 32'(rsp_err_v[d]), 32'd0);
      end
      rst_n_v = 3'b111;

      // Give every modelled word a known value.
      for (int d = 0; d < 3; d++) begin
         for (int w = 0; w < 32; w++) begin
            logic [31:0] v;
            v = $urandom;
            model_op(d, 1'b1, 2'b10, 1'b0, w * 4, v, exp_err, exp_rdata);
            xact(d, 1'b1, 2'b10, 1'b0, 10'(w * 4), v, got_err, got_rdata);
            check("init_err", 32'(got_err), 32'd0);
         end
      end

      tbl.push_back('{1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0, 32'hDEADBEEF});
      tbl.push_back('{1'b1, 2'b00, 1'b0, 10'h013, 32'h00000080, 1'b0, 32'h0});
      tbl.push_back('{1'b0, 2'b00, 1'b0, 10'h013, 32'h0, 1'b0, 32'hFFFFFF80});
      tbl.push_back('{1'b0, 2'b00, 1'b1, 10'h013, 32'h0, 1'b0, 32'h00000080});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0, 32'h80ADBEEF});
      tbl.push_back('{1'b0, 2'b01, 1'b0, 10'h012, 32'h0, 1'b0, 32'hFFFF80AD});
      tbl.push_back('{1'b0, 2'b01, 1'b1, 10'h012, 32'h0, 1'b0, 32'h000080AD});
      tbl.push_back('{1'b0, 2'b00, 1'b0, 10'h011, 32'h0, 1'b0, 32'hFFFFFFBE});
      tbl.push_back('{1'b1, 2'b10, 1'b0, 10'h020, 32'h11223344, 1'b0, 32'h0});
      tbl.push_back('{1'b1, 2'b01, 1'b0, 10'h021, 32'h0000CAFE, TRAP, 32'h0});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 1'b0, TRAP ? 32'h11223344 : 32'h1122CAFE});
      tbl.push_back('{1'b1, 2'b11, 1'b0, 10'h020, 32'hFFFFFFFF, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 1'b0, TRAP ? 32'h11223344 : 32'h1122CAFE});
      tbl.push_back('{1'b0, 2'b11, 1'b0, 10'h020, 32'h0, 1'b1, 32'h0});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 10'h013, 32'h0, TRAP, TRAP ? 32'h0 : 32'h80ADBEEF});
      tbl.push_back('{1'b0, 2'b01, 1'b1, 10'h011, 32'h0, TRAP, TRAP ? 32'h0 : 32'h0000BEEF});

      foreach (tbl[i]) begin
         model_op(0, tbl[i].we, tbl[i].size, tbl[i].uns, int'(tbl[i].addr), tbl[i].wdata, exp_err, exp_rdata);
         xact(0, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, got_err, got_rdata);
         check("tbl_err", 32'(got_err), 32'(tbl[i].err));
         check("tbl_rdata", got_rdata, tbl[i].rdata);
      end

      // Reset while a store waits: the store must never reach memory.
      model_op(2, 1'b0, 2'b10, 1'b0, 'h40, 32'h0, exp_err, prior);
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 10'h040; req_wdata = 32'h12345678; req_valid_v[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_v[2] = 1'b0;
      check("wait_ready_low", 32'(req_ready_v[2]), 32'd0);
      rst_n_v[2] = 1'b0;
      #1;
      check("wait_reset_ready", 32'(req_ready_v[2]), 32'd1);
      check("wait_reset_rsp_valid", 32'(rsp_valid_v[2]), 32'd0);
      repeat (2) @(negedge clk);
      check("wait_reset_rsp_valid_held", 32'(rsp_valid_v[2]), 32'd0);
      rst_n_v[2] = 1'b1;
      xact(2, 1'b0, 2'b10, 1'b0, 10'h040, 32'h0, got_err, got_rdata);
      check("aborted_store_no_commit", got_rdata, prior);

      // Reset during the response pulse clears it at once; the store stays.
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 10'h044; req_wdata = 32'hA5A55A5A; req_valid_v[0] = 1'b1;
      model_op(0, 1'b1, 2'b10, 1'b0, 'h44, 32'hA5A55A5A, exp_err, exp_rdata);
      @(posedge clk);
      @(negedge clk);
      req_valid_v[0] = 1'b0;
      @(negedge clk);
      check("resp_pulse_present", 32'(rsp_valid_v[0]), 32'd1);
      rst_n_v[0] = 1'b0;
      #1;
      check("resp_reset_rsp_valid", 32'(rsp_valid_v[0]), 32'd0);
      check("resp_reset_ready", 32'(req_ready_v[0]), 32'd1);
      @(negedge clk);
      rst_n_v[0] = 1'b1;
      xact(0, 1'b0, 2'b10, 1'b0, 10'h044, 32'h0, got_err, got_rdata);
      check("store_before_resp_reset", got_rdata, 32'hA5A55A5A);

      // A request held while busy is ignored, not queued.
      @(negedge clk);
      req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 10'h048; req_wdata = 32'h0BADF00D; req_valid_v[0] = 1'b1;
      model_op(0, 1'b1, 2'b10, 1'b0, 'h48, 32'h0BADF00D, exp_err, exp_rdata);
      @(posedge clk);
      @(negedge clk);
      check("busy_ready_low", 32'(req_ready_v[0]), 32'd0);
      req_addr = 10'h04C; req_wdata = 32'hFFFFFFFF;
      @(posedge clk);
      @(negedge clk);
      check("busy_rsp_valid", 32'(rsp_valid_v[0]), 32'd1);
      req_valid_v[0] = 1'b0;
      @(negedge clk);
      check("busy_ready_back", 32'(req_ready_v[0]), 32'd1);
      model_op(0, 1'b0, 2'b10, 1'b0, 'h4C, 32'h0, exp_err, exp_rdata);
      xact(0, 1'b0, 2'b10, 1'b0, 10'h04C, 32'h0, got_err, got_rdata);
      check("ignored_req_no_write", got_rdata, exp_rdata);
      xact(0, 1'b0, 2'b10, 1'b0, 10'h048, 32'h0, got_err, got_rdata);
      check("accepted_req_written", got_rdata, 32'h0BADF00D);

      for (int i = 0; i < 150; i++) begin
         int          d, a;
         logic        we, uns;
         logic [1:0]  sz;
         logic [31:0] wd;
         d   = $urandom_range(0, 2);
         we  = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         a   = $urandom_range(0, 127);
         wd  = $urandom;
         model_op(d, we, sz, uns, a, wd, exp_err, exp_rdata);
         xact(d, we, sz, uns, 10'(a), wd, got_err, got_rdata);
         check("rand_err", 32'(got_err), 32'(exp_err));
         check("rand_rdata", got_rdata, exp_rdata);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
